ahb_uart_tx: RTL and testbench
==============================

AHB_UART_TX -- requirements
Module: ahb_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set the transmit FIFO entry count (power of two, 2..32).
REQ-002 Parameter DEFAULT_DIV, default 16, SHALL set the reset value of BAUD_DIV (clocks per serial bit).
REQ-003 HCLK  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 HRESET  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 HSEL  input  1  SHALL be the slave select from the address decoder.
REQ-006 HADDR  input  32  SHALL be the address; only HADDR[3:2] is decoded.
REQ-007 HWRITE  input  1  SHALL be the direction (1 = write).
REQ-008 HTRANS  input  1  SHALL be the transfer-active flag (1 = valid transfer).
REQ-009 HREADY  input  1  SHALL be the muxed bus ready; an address phase is accepted only when it is 1.
REQ-010 HWDATA  input  32  SHALL be the write data, sampled in the data phase.
REQ-011 HRDATA  output  32  SHALL be the read data, valid in the data phase.
REQ-012 HREADYOUT  output  1  SHALL be the slave ready (0 = wait state).
REQ-013 TXD  output  1  SHALL be the serial line, idle high.
REQ-014 TX_BUSY  output  1  SHALL be 1 while the FIFO is non-empty or a frame is in flight.

Function
REQ-015 Address phase SHALL be captured (addr, write, valid) when HSEL & HTRANS & HREADY; data phase occurs in the following cycle.
REQ-016 Register map SHALL be: 0x0 TXDATA (W, HWDATA[7:0] pushed); 0x4 STATUS (R: bit0 busy, bit1 full, bit2 empty, bits[12:8] count); 0x8 BAUD_DIV (RW, 16 bits); 0xC CTRL (RW, bit0 enable).
REQ-017 Reads SHALL complete with zero wait states; unmapped/write-only reads SHALL return 0; writes to read-only locations SHALL be ignored.
REQ-018 A TXDATA write while the FIFO is full SHALL hold HREADYOUT low until an entry frees, then push and raise HREADYOUT in that cycle.
REQ-019 A TXDATA write that coincides with a pop on a full FIFO SHALL complete without a wait state.
REQ-020 The TX FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START when enable=1 and FIFO non-empty, popping one byte in the same cycle.
REQ-021 START SHALL drive TXD=0, DATA SHALL shift 8 bits LSB first, STOP SHALL drive TXD=1; each bit lasts exactly BAUD_DIV cycles.
REQ-022 STOP->START directly (no idle bit) SHALL occur when enable=1 and FIFO non-empty; otherwise STOP->IDLE.
REQ-023 BAUD_DIV SHALL be latched at frame start; writes mid-frame take effect on the next frame; a value of 0 SHALL be treated as 1.
REQ-024 Clearing enable mid-frame SHALL let the current frame finish; no new frame starts until enable=1.
REQ-025 FIFO count SHALL never wrap: no push when full, no pop when empty.

Reset
REQ-026 On HRESET=1 at a clock edge: FSM=IDLE, FIFO empty, TXD=1, TX_BUSY=0, HREADYOUT=1, HRDATA=0, BAUD_DIV=DEFAULT_DIV, CTRL.enable=0, pending data phase discarded.
REQ-027 Reset asserted mid-frame or mid-wait-state SHALL abort it; TXD=1 on the cycle following the reset edge.

Structure
REQ-028 Package ahb_uart_pkg SHALL hold register offsets, the FSM state enumeration and the FIFO_DEPTH/DEFAULT_DIV defaults.
REQ-029 The FIFO SHALL be a sub-module sync_fifo (push/pop/full/empty/count, single clock, synchronous active-high reset).

Verification
REQ-030 Write CTRL=1, TXDATA=0xA5, BAUD_DIV=4 -> TXD: start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 4 cycles; 40 cycles total; TX_BUSY falls after stop.
REQ-031 Enable=0, write 9 bytes with depth 8 -> 9th write stalls (HREADYOUT=0); set enable=1 -> stall releases when first byte pops; STATUS count=8.
REQ-032 Two queued bytes 0x01, 0x80 -> second start bit immediately follows first stop bit, no idle gap.
REQ-033 Write BAUD_DIV=2 mid-frame at DIV=8 -> current frame remains 8 cycles/bit, next frame 2 cycles/bit; BAUD_DIV=0 -> 1 cycle/bit.
REQ-034 Assert HRESET during DATA state of 0x55 -> TXD=1 next cycle, STATUS reads 0x4 (empty), BAUD_DIV reads 16.
REQ-035 Read 0x0 and issue transfer with HTRANS=0 -> HRDATA=0, no FIFO push, HREADYOUT=1.

Source files
------------

// File: rtl/ahb_uart_pkg.sv
// Shared definitions for the AHB-attached UART transmitter: register offsets,
// TX state encoding, bus data-phase payload and parameter defaults.
package ahb_uart_pkg;

  localparam int unsigned FIFO_DEPTH_DEF  = 8;
  localparam int unsigned DEFAULT_DIV_DEF = 16;
  localparam int unsigned DIV_W           = 16;
  localparam int unsigned DATA_W          = 8;

  // Word offsets as seen on HADDR[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic [1:0] addr;
    logic       write;
    logic       valid;
  } dphase_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pushes on full are dropped unless a pop frees a slot
// in the same cycle, and pops on empty are ignored.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign rdata     = mem[rd_ptr];
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ahb_uart_tx.sv
// AHB-Lite slave feeding a byte FIFO that drains into an 8N1 serial
// transmitter with a programmable clocks-per-bit divider.
module ahb_uart_tx
  import ahb_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic        HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        TXD,
  output logic        TX_BUSY
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  dphase_t              dp_q;
  logic                 enable_q;
  logic [DIV_W-1:0]     baud_div_q;
  logic                 fifo_push_c;
  logic                 fifo_pop_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [DATA_W-1:0]    fifo_rdata;
  logic                 wr_txdata_c;
  logic                 stall_c;

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_W-1:0]    shreg_q, shreg_d;
  logic                 txd_q, txd_d;
  logic                 launch_c;
  logic                 bit_end_c;
  logic                 start_ok_c;
  logic [DIV_W-1:0]     eff_div_c;
  logic                 unused_bits_c;

  assign unused_bits_c = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

  // A TXDATA write on a full FIFO waits unless the transmitter pops this cycle
  assign wr_txdata_c = dp_q.valid & dp_q.write & (dp_q.addr == REG_TXDATA);
  assign stall_c     = wr_txdata_c & fifo_full & ~fifo_pop_c;
  assign fifo_push_c = wr_txdata_c & ~stall_c;
  assign HREADYOUT   = ~stall_c;
  assign TX_BUSY     = ~fifo_empty | (state_q != ST_IDLE);
  assign TXD         = txd_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_q <= '0;
    end else if (HREADY) begin
      dp_q <= '{addr: HADDR[3:2], write: HWRITE, valid: HSEL & HTRANS};
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      enable_q   <= 1'b0;
      baud_div_q <= DIV_W'(DEFAULT_DIV);
    end else if (dp_q.valid && dp_q.write) begin
      case (dp_q.addr)
        REG_BAUD: baud_div_q <= HWDATA[DIV_W-1:0];
        REG_CTRL: enable_q   <= HWDATA[0];
        default:  ;
      endcase
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_q.valid && !dp_q.write) begin
      case (dp_q.addr)
        REG_STATUS: HRDATA = {19'd0, 5'(fifo_count), 5'd0, fifo_empty, fifo_full, TX_BUSY};
        REG_BAUD:   HRDATA = 32'(baud_div_q);
        REG_CTRL:   HRDATA = 32'(enable_q);
        default:    HRDATA = '0;
      endcase
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (fifo_push_c),
    .pop   (fifo_pop_c),
    .wdata (HWDATA[DATA_W-1:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign eff_div_c  = (baud_div_q == '0) ? DIV_W'(1) : baud_div_q;
  assign bit_end_c  = (cnt_q == (div_q - DIV_W'(1)));
  assign start_ok_c = enable_q & ~fifo_empty;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(1);
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  // Frame sequencing; a new frame may launch from IDLE or straight out of STOP
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + DIV_W'(1);
    div_d      = div_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    launch_c   = 1'b0;
    fifo_pop_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        txd_d    = 1'b1;
        launch_c = start_ok_c;
      end
      ST_START: if (bit_end_c) begin
        state_d = ST_DATA;
        cnt_d   = '0;
        bit_d   = '0;
        txd_d   = shreg_q[0];
      end
      ST_DATA: if (bit_end_c) begin
        cnt_d = '0;
        if (bit_q == 3'd7) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end else begin
          bit_d   = bit_q + 3'd1;
          shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          txd_d   = shreg_q[1];
        end
      end
      ST_STOP: if (bit_end_c) begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        txd_d    = 1'b1;
        launch_c = start_ok_c;
      end
      default: state_d = ST_IDLE;
    endcase
    if (launch_c) begin
      fifo_pop_c = 1'b1;
      state_d    = ST_START;
      cnt_d      = '0;
      txd_d      = 1'b0;
      shreg_d    = fifo_rdata;
      div_d      = eff_div_c;
    end
  end

endmodule

// File: tb/tb_ahb_uart_tx.sv
// Scoreboard bench for ahb_uart_tx: bus reads and serial frames are checked by
// independent monitors against expectations queued when stimulus is issued.
module tb_ahb_uart_tx;

  localparam logic [31:0] A_TXDATA = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_BAUD   = 32'h8;
  localparam logic [31:0] A_CTRL   = 32'hC;

  logic        HCLK = 1'b0;
  logic        HRESET, HSEL, HWRITE, HTRANS, HREADY;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HREADYOUT, TXD, TX_BUSY;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .TXD(TXD), .TX_BUSY(TX_BUSY)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc = 0;
  int          model_div = 16;
  bit          mon_busy = 1'b0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] rd_exp[$];
  string       rd_name[$];
  int unsigned starts[$];

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic int eff_div(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Read monitor: a read data phase completes on any cycle with HREADYOUT high
  initial begin : rd_mon
    bit pend = 1'b0;
    forever begin
      @(negedge HCLK); #1;
      if (HRESET !== 1'b0) begin
        if (pend && rd_exp.size() > 0) begin
          void'(rd_exp.pop_front());
          void'(rd_name.pop_front());
        end
        pend = 1'b0;
        continue;
      end
      if (pend && HREADYOUT === 1'b1) begin
        if (rd_exp.size() == 0) check("rd_unexpected", HRDATA, 32'hDEAD_BEEF);
        else check(rd_name.pop_front(), HRDATA, rd_exp.pop_front());
      end
      if (HREADY === 1'b1) pend = (HSEL === 1'b1) && (HTRANS === 1'b1) && (HWRITE === 1'b0);
    end
  end

  // Serial monitor: decodes each frame cycle by cycle at the divider in force at its start
  initial begin : tx_mon
    logic [7:0] e, rx;
    int d, bad, idx;
    bit abort;
    logic expb;
    forever begin
      @(negedge HCLK); #1;
      if (HRESET !== 1'b0) continue;
      if (TXD === 1'b0) begin
        if (exp_bytes.size() == 0) begin
          check("tx_unexpected_start", 32'(TXD), 32'd1);
        end else begin
          mon_busy = 1'b1;
          e = exp_bytes.pop_front();
          d = eff_div(model_div);
          starts.push_back(cyc);
          bad = 0; rx = '0; abort = 1'b0;
          for (int j = 1; j < 10 * d; j++) begin
            @(negedge HCLK); #1;
            if (HRESET !== 1'b0) begin abort = 1'b1; break; end
            idx = j / d;
            expb = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : e[idx-1];
            if (TXD !== expb) bad++;
            if (idx >= 1 && idx <= 8 && (j % d) == d / 2) rx[idx-1] = TXD;
          end
          if (!abort) begin
            check($sformatf("frame_data_%02h", e), 32'(rx), 32'(e));
            check($sformatf("frame_timing_%02h_bad_samples", e), 32'(bad), 32'd0);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready(output int waits);
    bit ok = 1'b0;
    waits = 0;
    for (int i = 0; i < 2000; i++) begin
      if (HREADY === 1'b1) begin ok = 1'b1; break; end
      waits++;
      @(negedge HCLK);
    end
    if (ok) @(posedge HCLK);
    else check("hready_timeout", 32'(HREADY), 32'd1);
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    if (a == A_TXDATA) exp_bytes.push_back(d[7:0]);
    if (a == A_BAUD) model_div = int'(d[15:0]);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int waits);
    int w0;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 1'b1; HWRITE = 1'b1; HADDR = a;
    model_write(a, d);
    wait_ready(w0);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 1'b0; HWRITE = 1'b0; HWDATA = d;
    wait_ready(waits);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int w;
    bus_write(a, d, w);
  endtask

  // Back-to-back pipelined writes; reports wait states on the second data phase
  task automatic bus_write_pair(input logic [31:0] a0, input logic [31:0] d0,
                                input logic [31:0] a1, input logic [31:0] d1, output int waits1);
    int w;
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 1'b1; HWRITE = 1'b1; HADDR = a0;
    model_write(a0, d0);
    wait_ready(w);
    @(negedge HCLK);
    HWDATA = d0; HADDR = a1;
    model_write(a1, d1);
    wait_ready(w);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 1'b0; HWRITE = 1'b0; HWDATA = d1;
    wait_ready(waits1);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    int w;
    rd_exp.push_back(exp);
    rd_name.push_back(name);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 1'b1; HWRITE = 1'b0; HADDR = a;
    wait_ready(w);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 1'b0;
    wait_ready(w);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4000; i++) begin
      @(negedge HCLK);
      if (exp_bytes.size() == 0 && !mon_busy && TX_BUSY === 1'b0) break;
    end
    @(negedge HCLK);
    check({name, "_queue_empty"}, 32'(exp_bytes.size()), 32'd0);
    check({name, "_tx_busy_low"}, 32'(TX_BUSY), 32'd0);
    check({name, "_txd_idle"}, 32'(TXD), 32'd1);
  endtask

  task automatic wait_frame_start(input string name);
    for (int i = 0; i < 500; i++) begin
      if (mon_busy) break;
      @(negedge HCLK);
    end
    check({name, "_frame_started"}, 32'(mon_busy), 32'd1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int waits;
    logic [7:0] b;
    int dv, n;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 1'b0; HWRITE = 1'b0;
    HADDR = '0; HWDATA = '0;
    repeat (3) @(negedge HCLK);
    check("rst_txd", 32'(TXD), 32'd1);
    check("rst_tx_busy", 32'(TX_BUSY), 32'd0);
    check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    HRESET = 1'b0;
    bus_read(A_STATUS, 32'h4, "rst_status");
    bus_read(A_BAUD, 32'd16, "rst_baud");
    bus_read(A_CTRL, 32'd0, "rst_ctrl");

    // Single 0xA5 frame at 4 clocks per bit
    wr(A_CTRL, 32'd1);
    wr(A_BAUD, 32'd4);
    wr(A_TXDATA, 32'hA5);
    @(negedge HCLK);
    check("a5_tx_busy_high", 32'(TX_BUSY), 32'd1);
    wait_drain("a5");

    // Fill FIFO while disabled, then enable and push together, then stall
    wr(A_CTRL, 32'd0);
    for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'($urandom_range(0, 255)));
    bus_read(A_STATUS, 32'h0803, "full_status");
    bus_write_pair(A_CTRL, 32'd1, A_TXDATA, 32'($urandom_range(0, 255)), waits);
    check("push_with_pop_no_wait", 32'(waits), 32'd0);
    bus_read(A_STATUS, 32'h0803, "status_after_pair");
    bus_write(A_TXDATA, 32'($urandom_range(0, 255)), waits);
    check("full_write_stalled", 32'(waits > 0), 32'd1);
    bus_read(A_STATUS, 32'h0803, "status_after_stall");
    wait_drain("fill");

    // Two queued bytes go out back to back with no idle bit
    wr(A_CTRL, 32'd0);
    wr(A_BAUD, 32'd3);
    wr(A_TXDATA, 32'h01);
    wr(A_TXDATA, 32'h80);
    starts.delete();
    wr(A_CTRL, 32'd1);
    wait_drain("b2b");
    if (starts.size() == 2) check("b2b_gap_cycles", starts[1] - starts[0], 32'd30);
    else check("b2b_frame_count", 32'(starts.size()), 32'd2);

    // Divider change mid-frame applies to the next frame; zero means one
    wr(A_BAUD, 32'd8);
    wr(A_TXDATA, 32'($urandom_range(0, 255)));
    wait_frame_start("div8");
    wr(A_BAUD, 32'd2);
    wr(A_TXDATA, 32'($urandom_range(0, 255)));
    wait_drain("div_change");
    wr(A_BAUD, 32'd0);
    wr(A_TXDATA, 32'($urandom_range(0, 255)));
    wait_drain("div_zero");
    bus_read(A_BAUD, 32'd0, "baud_zero_readback");

    // Randomized bursts at random dividers
    for (int k = 0; k < 6; k++) begin
      dv = $urandom_range(1, 5);
      n  = $urandom_range(1, 3);
      wr(A_BAUD, 32'(dv));
      bus_read(A_BAUD, 32'(dv), "rand_baud_readback");
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        wr(A_TXDATA, 32'(b));
      end
      wait_drain("rand");
    end

    // Idle transfer and write-only read
    wr(A_CTRL, 32'd0);
    bus_read(A_TXDATA, 32'd0, "txdata_read_zero");
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 1'b0; HWRITE = 1'b1; HADDR = A_TXDATA;
    @(negedge HCLK);
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'h77;
    check("idle_xfer_hreadyout", 32'(HREADYOUT), 32'd1);
    @(negedge HCLK);
    bus_read(A_STATUS, 32'h4, "idle_xfer_no_push");

    // Reset in the middle of the data bits of 0x55
    wr(A_CTRL, 32'd1);
    wr(A_BAUD, 32'd8);
    wr(A_TXDATA, 32'h55);
    wait_frame_start("rst55");
    repeat (20) @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("midframe_rst_txd", 32'(TXD), 32'd1);
    check("midframe_rst_busy", 32'(TX_BUSY), 32'd0);
    check("midframe_rst_hrdata", HRDATA, 32'd0);
    HRESET = 1'b0;
    exp_bytes.delete();
    model_div = 16;
    bus_read(A_STATUS, 32'h4, "post_rst_status");
    bus_read(A_BAUD, 32'd16, "post_rst_baud");
    bus_read(A_CTRL, 32'd0, "post_rst_ctrl");
    repeat (20) @(negedge HCLK);
    check("post_rst_txd_idle", 32'(TXD), 32'd1);

    check("rd_scoreboard_drained", 32'(rd_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
